// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: draw-request, tile/image ROM and frame-buffer signals of the sprite blitter
interface sprite_blitter_if #(
   parameter int COLOR_W = 3
);
   logic               copy_enable;
   logic [1:0]         memory_select;
   logic               black;
   logic [7:0]         dst_x;
   logic [6:0]         dst_y;
   logic [5:0]         src_index;
   logic [1:0]         rom_select;
   logic [14:0]        rom_addr;
   logic [COLOR_W-1:0] rom_data;
   logic [7:0]         fb_x;
   logic [6:0]         fb_y;
   logic [COLOR_W-1:0] fb_color;
   logic               fb_we;
   logic               finished;
   modport master (
      output copy_enable, memory_select, black, dst_x, dst_y, src_index, rom_data,
      input  rom_select, rom_addr, fb_x, fb_y, fb_color, fb_we, finished
   );
   modport slave (
      input  copy_enable, memory_select, black, dst_x, dst_y, src_index, rom_data,
      output rom_select, rom_addr, fb_x, fb_y, fb_color, fb_we, finished
   );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a full-screen image or a keyed, clipped tile from ROM into the frame buffer
module sprite_blitter #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int TILE     = 16,
   parameter int COLOR_W  = 3,
   parameter int KEY      = 0
) (
   input logic             clock,
   input logic             reset,
   sprite_blitter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic        black_q, black_d;
   logic [7:0]  dx_q, dx_d, x_q, x_d, px_q, px_d;
   logic [6:0]  dy_q, dy_d, y_q, y_d, py_q, py_d;
   logic [5:0]  idx_q, idx_d;
   logic        v_q, v_d, inb_q, inb_d;
   logic        tile, last_x, last_y;
   logic [8:0]  sx, sy;
   assign tile   = sel_q == 2'd3;
   assign last_x = x_q == (tile ? 8'(TILE - 1) : 8'(SCREEN_W - 1));
   assign last_y = y_q == (tile ? 7'(TILE - 1) : 7'(SCREEN_H - 1));
   // 9-bit sums so a tile hanging off the right/bottom edge is clipped, not wrapped
   assign sx     = 9'(dx_q) + 9'(x_q);
   assign sy     = 9'(dy_q) + 9'(y_q);
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      black_d = black_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      idx_d   = idx_q;
      x_d     = x_q;
      y_d     = y_q;
      v_d     = state_q == RUN;
      px_d    = tile ? sx[7:0] : x_q;
      py_d    = tile ? sy[6:0] : y_q;
      inb_d   = !tile || (sx < 9'(SCREEN_W) && sy < 9'(SCREEN_H));
      case (state_q)
         IDLE: if (bus.copy_enable) begin
            sel_d   = bus.memory_select;
            black_d = bus.black;
            dx_d    = bus.dst_x;
            dy_d    = bus.dst_y;
            idx_d   = bus.src_index;
            x_d     = '0;
            y_d     = '0;
            state_d = RUN;
         end
         RUN: begin
            x_d     = last_x ? 8'd0 : x_q + 8'd1;
            y_d     = y_q + 7'(last_x);
            state_d = (last_x && last_y) ? FLUSH : RUN;
         end
         FLUSH:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         black_q <= 1'b0;
         dx_q    <= '0;
         dy_q    <= '0;
         idx_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         v_q     <= 1'b0;
         px_q    <= '0;
         py_q    <= '0;
         inb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         black_q <= black_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         idx_q   <= idx_d;
         x_q     <= x_d;
         y_q     <= y_d;
         v_q     <= v_d;
         px_q    <= px_d;
         py_q    <= py_d;
         inb_q   <= inb_d;
      end
   end
   assign bus.rom_select = sel_q;
   assign bus.rom_addr   = tile ? 15'(idx_q) * 15'(TILE * TILE) + 15'(y_q) * 15'(TILE) + 15'(x_q)
                                : 15'(y_q) * 15'(SCREEN_W) + 15'(x_q);
   // rom_data arrives in the write cycle, so keying and colour are resolved combinationally
   assign bus.fb_we      = v_q && (!tile || (inb_q && bus.rom_data != COLOR_W'(KEY)));
   assign bus.fb_color   = (v_q && !(tile && black_q)) ? bus.rom_data : '0;
   assign bus.fb_x       = px_q;
   assign bus.fb_y       = py_q;
   assign bus.finished   = state_q == DONE;
endmodule
